// File: rtl/mux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl_pkg
//  Description : Shared definitions for the 4:1 mux scan sequencer.
//                The package holds the FSM state encodings, the channel
//                count, the select width and the last-channel index.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Index of the final channel in a scan
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage : mux_scan_ctrl_pkg
`default_nettype wire

// File: rtl/mux_scan_ctrl_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Loadable down-counter that times how long the mux select
//                is held before the sample cycle. 'last' flags a count of
//                one, which is the final settle cycle.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous reset, active low
//                load     - load load_val (has priority over dec)
//                load_val - value loaded into the counter
//                dec      - decrement the counter by one
//                cnt      - current count
//                last     - high while cnt == 1
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule : settle_timer
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Scans a 4:1 mux through channels 0..3. Each select value
//                is held for SETTLE cycles plus one sample cycle; the four
//                sampled bits are published together as a snapshot with a
//                one-cycle valid pulse. Supports single-shot and continuous
//                scanning.
//  Ports       : clk       - clock, rising edge
//                rst_n     - synchronous reset, active low
//                start     - request one scan (honoured in IDLE/DONE only)
//                mode_cont - rescan automatically after each DONE
//                mux_out   - output of the 4:1 mux
//                s1, s0    - mux select, registered
//                snapshot  - bit k = mux_out sampled with {s1,s0} == k
//                valid     - one-cycle pulse with a new snapshot
//                busy      - high from scan start through DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 2,   // 1..255, must fit in CNT_W bits
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_cont,
    input  logic              mux_out,
    output logic              s1,
    output logic              s0,
    output logic [NUM_CH-1:0] snapshot,
    output logic              valid,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    logic [1:0]        state;
    logic [SEL_W-1:0]  sel;
    // Channels 0..2 are buffered here; channel 3 goes straight into the
    // snapshot on the same edge, so it needs no shadow bit.
    logic [NUM_CH-2:0] shadow;

    logic              go;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_last;
    logic [CNT_W-1:0]  tmr_cnt;

    assign go = start | mode_cont;

    // Timer reloads whenever a channel's settle window begins.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE:   tmr_load = go;
            ST_SETTLE: tmr_dec  = ~tmr_last;
            ST_SAMPLE: tmr_load = (sel != LAST_CH);
            ST_DONE:   tmr_load = go;
            default: ;
        endcase
    end

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .last     (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            shadow   <= '0;
            snapshot <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_SETTLE;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_last) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (sel != LAST_CH) begin
                        shadow[sel] <= mux_out;
                        sel         <= sel + SEL_W'(1);
                        state       <= ST_SETTLE;
                    end else begin
                        snapshot <= {mux_out, shadow};
                        valid    <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid <= 1'b0;
                    sel   <= '0;
                    if (go) begin
                        // Back-to-back scan: busy stays high, no idle gap.
                        state <= ST_SETTLE;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_ctrl
//  Description : Directed self-checking bench for mux_scan_ctrl. Three
//                instances (SETTLE = 2, 1, 255) each drive a behavioural
//                4:1 mux built from a 4-bit input vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v, mode_v, mux_v, s1_v, s0_v, valid_v, busy_v;
    logic [3:0] din_v  [3];
    logic [3:0] snap_v [3];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign mux_v[g] = din_v[g][{s1_v[g], s0_v[g]}];
    end

    mux_scan_ctrl #(.SETTLE(2), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode_cont(mode_v[0]),
        .mux_out(mux_v[0]), .s1(s1_v[0]), .s0(s0_v[0]),
        .snapshot(snap_v[0]), .valid(valid_v[0]), .busy(busy_v[0]));

    mux_scan_ctrl #(.SETTLE(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode_cont(mode_v[1]),
        .mux_out(mux_v[1]), .s1(s1_v[1]), .s0(s0_v[1]),
        .snapshot(snap_v[1]), .valid(valid_v[1]), .busy(busy_v[1]));

    mux_scan_ctrl #(.SETTLE(255), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode_cont(mode_v[2]),
        .mux_out(mux_v[2]), .s1(s1_v[2]), .s0(s0_v[2]),
        .snapshot(snap_v[2]), .valid(valid_v[2]), .busy(busy_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_of(input int d);
        return 32'({s1_v[d], s0_v[d]});
    endfunction

    // Advance one clock; observe 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps until valid is seen; n = number of edges taken (budget on timeout).
    task automatic wait_valid(input int d, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid_v[d] && n < budget);
    endtask

    task automatic wait_sel(input int d, input logic [31:0] s, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (sel_of(d) != s && n < budget);
        check("wait_sel", sel_of(d), s);
    endtask

    task automatic count_valid(input int d, input int cycles, output int k);
        k = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (valid_v[d]) k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int prev;

        rst_n    = 1'b0;
        start_v  = '0;
        mode_v   = '0;
        din_v[0] = 4'b1101;   // i0..i3 = 1,0,1,1
        din_v[1] = 4'b1101;
        din_v[2] = 4'b0110;   // i0..i3 = 0,1,1,0
        step();
        step();

        // ---------------- reset state ----------------
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_sel%0d", d),   sel_of(d), 0);
            check($sformatf("rst_snap%0d", d),  32'(snap_v[d]), 0);
            check($sformatf("rst_valid%0d", d), 32'(valid_v[d]), 0);
            check($sformatf("rst_busy%0d", d),  32'(busy_v[d]), 0);
        end
        rst_n = 1'b1;
        step();

        // ---------------- single scan, SETTLE=2 ----------------
        start_v[0] = 1'b1;
        step();                     // E0
        start_v[0] = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            check($sformatf("s1_busy_%0d", i),  32'(busy_v[0]), 1);
            check($sformatf("s1_valid_%0d", i), 32'(valid_v[0]), (i == 12) ? 1 : 0);
            check($sformatf("s1_sel_%0d", i),   sel_of(0), (i < 12) ? i / 3 : 3);
            check($sformatf("s1_snap_%0d", i),  32'(snap_v[0]), (i == 12) ? 32'hD : 0);
            step();
        end
        check("s1_end_busy",  32'(busy_v[0]), 0);
        check("s1_end_valid", 32'(valid_v[0]), 0);
        check("s1_end_sel",   sel_of(0), 0);
        check("s1_end_snap",  32'(snap_v[0]), 32'hD);

        // ---------------- continuous mode ----------------
        mode_v[0] = 1'b1;
        step();                     // E0
        wait_valid(0, 40, n);
        check("cont_lat1", n, 12);
        check("cont_snap1", 32'(snap_v[0]), 32'hD);
        prev = cyc;
        wait_sel(0, 1, 20);         // scan 2, channel 0 already sampled
        din_v[0] = 4'b0110;
        wait_valid(0, 40, n);
        check("cont_per2", cyc - prev, 13);
        check("cont_snap2", 32'(snap_v[0]), 32'h7);
        prev = cyc;
        wait_valid(0, 40, n);
        check("cont_per3", cyc - prev, 13);
        check("cont_snap3", 32'(snap_v[0]), 32'h6);
        prev = cyc;
        wait_sel(0, 2, 20);
        mode_v[0] = 1'b0;           // drop mid-scan 4
        wait_valid(0, 40, n);
        check("cont_per4", cyc - prev, 13);
        check("cont_snap4", 32'(snap_v[0]), 32'h6);
        step();
        check("cont_idle_busy",  32'(busy_v[0]), 0);
        check("cont_idle_valid", 32'(valid_v[0]), 0);
        count_valid(0, 30, k);
        check("cont_no_more", k, 0);
        check("cont_hold_snap", 32'(snap_v[0]), 32'h6);

        // ---------------- start while busy ----------------
        din_v[0] = 4'b1011;
        start_v[0] = 1'b1;
        step();                     // E0
        start_v[0] = 1'b0;
        step();
        step();                     // now in SAMPLE of channel 0
        start_v[0] = 1'b1;
        step();                     // E3
        start_v[0] = 1'b0;
        check("busy_start_sel", sel_of(0), 1);
        wait_valid(0, 40, n);
        check("busy_start_lat", n, 9);
        check("busy_start_snap", 32'(snap_v[0]), 32'hB);
        count_valid(0, 30, k);
        check("busy_start_pulses", k, 0);
        check("busy_start_idle", 32'(busy_v[0]), 0);

        // ---------------- reset mid-scan ----------------
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        wait_sel(0, 2, 20);
        rst_n = 1'b0;
        step();
        check("mrst_sel",   sel_of(0), 0);
        check("mrst_snap",  32'(snap_v[0]), 0);
        check("mrst_valid", 32'(valid_v[0]), 0);
        check("mrst_busy",  32'(busy_v[0]), 0);
        rst_n = 1'b1;
        din_v[0] = 4'b1010;
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        wait_valid(0, 40, n);
        check("mrst_lat", n, 12);
        check("mrst_snap2", 32'(snap_v[0]), 32'hA);

        // ---------------- SETTLE=1 ----------------
        start_v[1] = 1'b1;
        step();                     // E0
        start_v[1] = 1'b0;
        step();
        check("set1_sel_e1", sel_of(1), 0);
        step();
        check("set1_sel_e2", sel_of(1), 1);
        wait_valid(1, 40, n);
        check("set1_lat", n + 2, 8);
        check("set1_snap", 32'(snap_v[1]), 32'hD);

        // ---------------- SETTLE=255 ----------------
        start_v[2] = 1'b1;
        step();
        start_v[2] = 1'b0;
        wait_valid(2, 1100, n);
        check("set255_lat", n, 1024);
        check("set255_snap", 32'(snap_v[2]), 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
